// File: rtl/controller.sv
// Control unit for the single-cycle RV32I-subset CPU.
// Decodes opcode/funct3/funct7[5] and the ALU zero flag into datapath
// control signals. Everything is combinational except a sticky status flag
// that records whether an unsupported opcode was ever clocked in, for use
// by debug and trap hooks.
module controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] result_select,
  output logic       mem_write,
  output logic       PC_select,
  output logic       ALU_select,
  output logic       reg_write,
  output logic       jump,
  output logic [2:0] ALU_control,
  output logic       illegal
);

  // Supported major opcodes
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_ITYPE  = 7'b0010011,
    OP_JAL    = 7'b1101111
  } opcode_t;

  // Coarse ALU class handed from the main decoder to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // ALU operation encodings seen by the datapath
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  // Writeback mux sources
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  logic    branch;
  logic    legal_opcode;
  alu_op_t alu_op;
  logic    is_sub;

  // Main decoder: opcode to datapath controls; unknown opcodes are inert
  always_comb begin
    reg_write     = 1'b0;
    ALU_select    = 1'b0;
    mem_write     = 1'b0;
    result_select = RES_ALU;
    branch        = 1'b0;
    alu_op        = ALU_OP_ADD;
    jump          = 1'b0;
    legal_opcode  = 1'b1;
    case (opcode)
      OP_LOAD: begin
        reg_write     = 1'b1;
        ALU_select    = 1'b1;
        result_select = RES_MEM;
      end
      OP_STORE: begin
        ALU_select = 1'b1;
        mem_write  = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        alu_op = ALU_OP_SUB;
      end
      OP_ITYPE: begin
        reg_write  = 1'b1;
        ALU_select = 1'b1;
        alu_op     = ALU_OP_FUNCT;
      end
      OP_JAL: begin
        reg_write     = 1'b1;
        result_select = RES_PC4;
        jump          = 1'b1;
      end
      default: begin
        legal_opcode = 1'b0;
      end
    endcase
  end

  // Only R-type (opcode bit 5 set) may subtract; addi ignores bit 30
  assign is_sub = opcode[5] & funct7b5;

  // ALU decoder: refine the ALU class into a concrete operation
  always_comb begin
    ALU_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: ALU_control = ALU_ADD;
      ALU_OP_SUB: ALU_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  ALU_control = is_sub ? ALU_SUB : ALU_ADD;
          3'b010:  ALU_control = ALU_SLT;
          3'b110:  ALU_control = ALU_OR;
          3'b111:  ALU_control = ALU_AND;
          default: ALU_control = ALU_ADD;
        endcase
      end
      default: ALU_control = ALU_ADD;
    endcase
  end

  // Taken branch or jump redirects the PC to PC+imm
  assign PC_select = (branch & zero) | jump;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if (!legal_opcode) begin
      illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the RV32I-subset controller.
module tb_controller;

  logic       clock;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] result_select;
  logic       mem_write;
  logic       PC_select;
  logic       ALU_select;
  logic       reg_write;
  logic       jump;
  logic [2:0] ALU_control;
  logic       illegal;

  int checks;
  int errors;

  // Control bundle order: {result_select, mem_write, PC_select, ALU_select,
  // reg_write, jump, ALU_control}
  logic [9:0] ctrl;
  assign ctrl = {result_select, mem_write, PC_select, ALU_select,
                 reg_write, jump, ALU_control};

  controller dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .result_select (result_select),
    .mem_write     (mem_write),
    .PC_select     (PC_select),
    .ALU_select    (ALU_select),
    .reg_write     (reg_write),
    .jump          (jump),
    .ALU_control   (ALU_control),
    .illegal       (illegal)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset    = 1'b0;
    opcode   = 7'b0000011;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    #2;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_illegal got %b want 0", illegal);
    end
    checks++;
    if (ctrl !== 10'b01_0_0_1_1_0_000) begin
      errors++;
      $display("[TB] FAIL reset_comb_lw got %b want %b", ctrl, 10'b01_0_0_1_1_0_000);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL legal_no_set got %b want 0", illegal);
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000;
    funct3 = 3'b111;
    funct7b5 = 1'b1;
    zero = 1'b1;
    #1;
    checks++;
    if (ctrl !== 10'b0) begin
      errors++;
      $display("[TB] FAIL illegal_00_ctrl got %b want 0", ctrl);
    end
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_before_edge got %b want 0", illegal);
    end
    @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_set got %b want 1", illegal);
    end
    opcode = 7'b1111111;
    #1;
    checks++;
    if (ctrl !== 10'b0) begin
      errors++;
      $display("[TB] FAIL illegal_7f_ctrl got %b want 0", ctrl);
    end
    @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_hold got %b want 1", illegal);
    end
    opcode = 7'b0110011;
    @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_sticky got %b want 1", illegal);
    end
  endtask

  task automatic test_decode();
    logic [6:0] op_v [14];
    logic [2:0] f3_v [14];
    logic       f7_v [14];
    logic       z_v  [14];
    logic [9:0] exp_v[14];
    op_v = '{7'b0000011, 7'b0000011, 7'b0100011, 7'b0110011, 7'b0110011,
             7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011,
             7'b0010011, 7'b0100011, 7'b0110011, 7'b0010011};
    f3_v = '{3'b000, 3'b111, 3'b010, 3'b000, 3'b000,
             3'b010, 3'b110, 3'b111, 3'b001, 3'b000,
             3'b010, 3'b000, 3'b101, 3'b111};
    f7_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 1'b0};
    z_v  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b0};
    exp_v = '{10'b01_0_0_1_1_0_000,  // lw
              10'b01_0_0_1_1_0_000,  // lw, funct/zero ignored
              10'b00_1_0_1_0_0_000,  // sw
              10'b00_0_0_0_1_0_001,  // sub
              10'b00_0_0_0_1_0_000,  // add
              10'b00_0_0_0_1_0_101,  // slt
              10'b00_0_0_0_1_0_011,  // or
              10'b00_0_0_0_1_0_010,  // and
              10'b00_0_0_0_1_0_000,  // R funct3 001 -> add
              10'b00_0_0_1_1_0_000,  // addi with bit30 set
              10'b00_0_0_1_1_0_101,  // slti
              10'b00_1_0_1_0_0_000,  // sw, zero ignored
              10'b00_0_0_0_1_0_000,  // R funct3 101 -> add
              10'b00_0_0_1_1_0_010}; // andi
    for (int i = 0; i < 14; i++) begin
      opcode   = op_v[i];
      funct3   = f3_v[i];
      funct7b5 = f7_v[i];
      zero     = z_v[i];
      #1;
      checks++;
      if (ctrl !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL decode_%0d op=%b got %b want %b", i, op_v[i], ctrl, exp_v[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    opcode = 7'b1100011;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    zero = 1'b1;
    #1;
    checks++;
    if (ctrl !== 10'b00_0_1_0_0_0_001) begin
      errors++;
      $display("[TB] FAIL beq_taken got %b want %b", ctrl, 10'b00_0_1_0_0_0_001);
    end
    zero = 1'b0;
    #1;
    checks++;
    if (ctrl !== 10'b00_0_0_0_0_0_001) begin
      errors++;
      $display("[TB] FAIL beq_not_taken got %b want %b", ctrl, 10'b00_0_0_0_0_0_001);
    end
    opcode = 7'b1101111;
    funct3 = 3'b110;
    #1;
    checks++;
    if (ctrl !== 10'b10_0_1_0_1_1_000) begin
      errors++;
      $display("[TB] FAIL jal got %b want %b", ctrl, 10'b10_0_1_0_1_1_000);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 7'b0000000;
    @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_preset got %b want 1", illegal);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear got %b want 0", illegal);
    end
    checks++;
    if (ctrl !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_comb_illegal got %b want 0", ctrl);
    end
    opcode = 7'b0010011;
    funct3 = 3'b000;
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL legal_after_reset got %b want 0", illegal);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_illegal();
    test_decode();
    test_branch_jump();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Control unit for the single-cycle RV32I-subset CPU.
- Combinationally decodes opcode/funct3/funct7[5] plus the ALU zero flag into datapath control: result mux, memory write, PC mux, ALU operand mux, register write, jump, ALU operation.
- Adds one clocked element: a sticky illegal-opcode status flag for debug and trap hooks.
- Sits between the instruction memory output and the datapath.

Parameters:
- none

Ports:
- clock  input  1  system clock; rising edge; only the illegal flag register uses it
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- opcode  input  7  instruction bits [6:0]
- funct3  input  3  instruction bits [14:12]
- funct7b5  input  1  instruction bit 30
- zero  input  1  ALU zero flag of the current instruction
- result_select  output  2  writeback mux: 00 ALU result, 01 data memory read, 10 PC+4
- mem_write  output  1  data memory write enable
- PC_select  output  1  1 = next PC is PC+imm (branch/jump target); 0 = PC+4
- ALU_select  output  1  ALU operand B: 1 = immediate, 0 = register rs2
- reg_write  output  1  register file write enable
- jump  output  1  instruction is jal
- ALU_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  output  1  registered sticky flag: an unsupported opcode was decoded

Behaviour:
- All outputs except illegal are purely combinational from current inputs; zero latency; no dependence on clock or reset.
- Main decode. Each row lists reg_write, ALU_select, mem_write, result_select, branch, ALU_op, jump; branch and ALU_op are internal:
  - 0000011 lw: 1, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, 1, 1, 00, 0, 00, 0
  - 0110011 R-type: 1, 0, 0, 00, 0, 10, 0
  - 1100011 beq: 0, 0, 0, 00, 1, 01, 0
  - 0010011 I-type ALU: 1, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, 0, 0, 10, 0, 00, 1
  - Any other opcode, including 0000000 and 1111111: all outputs 0, ALU_control 000, so no register or memory side effects.
- PC_select = (branch AND zero) OR jump.
- ALU decode:
  - ALU_op 00 -> 000 (add).
  - ALU_op 01 -> 001 (sub).
  - ALU_op 10, by funct3:
    - 000: 001 (sub) if opcode[5] AND funct7b5, else 000. addi never subtracts, regardless of bit 30.
    - 010: 101 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - Any other funct3: 000.
- No X or Z on any output for any input combination; every case has an explicit default.
- illegal register:
  - Asynchronous clear to 0 when reset = 0.
  - On each rising clock with reset = 1: set to 1 if the current opcode is outside the six supported values.
  - Once set, holds 1 until the next reset; a supported opcode never clears it.
- Reset asserted mid-operation clears illegal immediately, with no clock needed. Combinational outputs are unaffected by reset.
- funct3, funct7b5 and zero are ignored for lw, sw and jal, except that zero is also irrelevant for all non-beq opcodes.

Test Plan:
- Opcode 0000000 then 1111111, reset = 1, one clock each -> all control outputs 0, ALU_control 000; illegal goes to 1 after the first edge and stays 1.
- lw 0000011 -> reg_write 1, ALU_select 1, result_select 01, mem_write 0, ALU_control 000. sw 0100011 -> mem_write 1, ALU_select 1, reg_write 0, ALU_control 000.
- R-type 0110011:
  - funct3 000, funct7b5 1 -> ALU_control 001.
  - funct3 000, funct7b5 0 -> 000.
  - funct3 010 / 110 / 111 -> 101 / 011 / 010.
  - In all cases reg_write 1, ALU_select 0.
- beq 1100011: zero 1 -> PC_select 1, ALU_control 001, reg_write 0. zero 0 -> PC_select 0.
- I-type 0010011, funct3 000, funct7b5 1 -> ALU_control 000 (addi), ALU_select 1, reg_write 1. jal 1101111, zero 0 -> jump 1, PC_select 1, result_select 10, reg_write 1.
- With illegal = 1, drive reset low between clock edges -> illegal reads 0 immediately. Release reset and apply a legal opcode with clocks -> illegal stays 0.
